// File: rtl/rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_decode_arbiter
// Purpose  : 16-way round-robin arbiter with capped tenure, 4-bit index and
//            one-hot (4x16 decoded) grant outputs.
// Revision : 1.0 - initial release
// ============================================================================
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  grant_id,
  output logic        grant_valid,
  output logic        timeout
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_grant = 2'd1;
  localparam logic [1:0] c_st_gap   = 2'd2;

  localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

  logic [1:0] r_state;
  logic [3:0] r_ptr;
  logic [3:0] r_hold_cnt;
  logic [3:0] r_grant_id;
  logic       r_grant_valid;
  logic       r_timeout;

  logic [3:0] w_idx;
  logic [3:0] w_sel;
  logic       w_any;
  logic       w_arb;
  logic       w_drop;
  logic       w_expire;

  // Rotating priority search; scanning downward lets the offset nearest ptr win.
  always_comb begin
    w_idx = 4'd0;
    w_sel = 4'd0;
    w_any = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      w_idx = r_ptr + 4'(k);
      if (req[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_arb    = en && w_any;
  // A requester dropping its line takes precedence over tenure expiry.
  assign w_drop   = !en || !req[r_grant_id];
  assign w_expire = !w_drop && (r_hold_cnt == c_max_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_ptr         <= 4'd0;
      r_hold_cnt    <= 4'd0;
      r_grant_id    <= 4'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        c_st_grant: begin
          if (w_drop || w_expire) begin
            r_state       <= c_st_gap;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= 4'd0;
            r_ptr         <= r_grant_id + 4'd1;
            r_timeout     <= w_expire;
          end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end
        default: begin
          // IDLE and the single GAP cycle both arbitrate on their next edge.
          if (w_arb) begin
            r_state       <= c_st_grant;
            r_grant_id    <= w_sel;
            r_grant_valid <= 1'b1;
            r_hold_cnt    <= 4'd1;
          end else begin
            r_state <= c_st_idle;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_decode
    assign grant[i] = r_grant_valid && (r_grant_id == 4'(i));
  end

  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire
